// File: rtl/pc_gen_if.sv
// Purpose : bundles the EX-side redirect requests and the IF-side fetch handshake of pc_gen.
// Latency : n/a (signal bundle only).
// Backpressure: if_ready_i from fetch holds pc_o/pc_valid_o; master = pc_gen, slave = EX/IF side.
interface pc_gen_if;
  // EX / hazard side
  logic        stall_i;     // hazard stall, hold PC
  logic        br_en_i;     // EX holds a conditional branch
  logic        br_zero_i;   // branch condition true
  logic        jump_i;      // EX holds jal/jalr
  logic [31:0] target_i;    // branch/jump target
  logic        trap_i;      // trap/interrupt redirect
  logic [31:0] trap_vec_i;  // trap vector
  // IF side
  logic        if_ready_i;  // fetch accepts pc_o this cycle
  logic [31:0] pc_o;        // fetch address
  logic        pc_valid_o;  // pc_o is a valid request
  logic        flush_o;     // kill IF/ID contents
  logic        redirect_o;  // first cycle at a redirected PC
  logic        misalign_o;  // misaligned jump/branch target

  modport master (
    input  stall_i, br_en_i, br_zero_i, jump_i, target_i, trap_i, trap_vec_i, if_ready_i,
    output pc_o, pc_valid_o, flush_o, redirect_o, misalign_o
  );

  modport slave (
    output stall_i, br_en_i, br_zero_i, jump_i, target_i, trap_i, trap_vec_i, if_ready_i,
    input  pc_o, pc_valid_o, flush_o, redirect_o, misalign_o
  );
endinterface

// File: rtl/pc_gen.sv
// Purpose : RV32 program-counter generation with branch/jump/trap redirect and IF/ID flush.
// Latency : redirect or sequential advance visible on pc_o one cycle after the request.
// Backpressure: pc_o/pc_valid_o hold while !if_ready_i or stall_i; a redirect overrides both.
// Ports   : clk, rst_n (async active-low); bus (pc_gen_if.master) carries all requests and
//           the fetch handshake, plus flush_o / redirect_o / misalign_o status pulses.
// Option  : PC_MISALIGN_TRAP_EN - jump/branch targets with bit1 set raise misalign_o instead
//           of redirecting; otherwise target bits [1:0] are forced to zero.
module pc_gen #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2            // 1..7
) (
  input logic       clk,
  input logic       rst_n,
  pc_gen_if.master  bus
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // Counter holds remaining flush cycles minus one, so S_FLUSH lasts exactly FLUSH_CYCLES.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        redirect_q, redirect_d;
  logic        misalign_q, misalign_d;

  logic        active;
  logic        in_flush;
  logic        trap_take;
  logic        jb_take;
  logic        jb_bad;
  logic [31:0] jb_target;
  logic        unused_tgt_lo;

  // Low target bits never reach the PC directly; bit1 only feeds the misalign check.
  assign unused_tgt_lo = ^bus.target_i[1:0];

  always_comb begin
    active    = (state_q != S_BOOT);
    in_flush  = (state_q == S_FLUSH);
    trap_take = active & bus.trap_i;
    // Jump/branch requests during a flush belong to killed instructions; trap has priority.
    jb_take   = active & ~in_flush & ~bus.trap_i &
                (bus.jump_i | (bus.br_en_i & bus.br_zero_i));
    jb_target = {bus.target_i[31:2], 2'b00};
`ifdef PC_MISALIGN_TRAP_EN
    jb_bad    = jb_take & bus.target_i[1];
`else
    jb_bad    = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;

    if (!active) begin
      state_d = S_RUN;
    end else begin
      if (in_flush) begin
        if (cnt_q == 3'd0) state_d = S_RUN;
        else               cnt_d   = cnt_q - 3'd1;
      end

      if (trap_take) begin
        pc_d       = bus.trap_vec_i;
        redirect_d = 1'b1;
        state_d    = S_FLUSH;
        cnt_d      = FLUSH_LOAD;
      end else if (jb_bad) begin
        // Misaligned target: hold PC and state, let the trap unit respond.
        misalign_d = 1'b1;
      end else if (jb_take) begin
        pc_d       = jb_target;
        redirect_d = 1'b1;
        state_d    = S_FLUSH;
        cnt_d      = FLUSH_LOAD;
      end else if (bus.if_ready_i && !bus.stall_i) begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_valid_o = (state_q != S_BOOT);
  assign bus.flush_o    = (state_q == S_FLUSH);
  assign bus.redirect_o = redirect_q;
  assign bus.misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Purpose : directed self-checking bench for pc_gen (RESET_PC=0, FLUSH_CYCLES=2).
// Latency : each vector is applied, one clock edge taken, outputs compared 1 time unit later.
// Backpressure: if_ready_i/stall_i driven per vector to exercise hold behaviour.
module tb_pc_gen;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  pc_gen_if bus();

  pc_gen #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, br_en, br_zero, jump;
    logic [31:0] target;
    logic        trap;
    logic [31:0] tvec;
    logic        rdy;
    logic [31:0] epc;
    logic        eflush, eredir;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  function automatic vec_t mkv(input logic stall, input logic br_en, input logic br_zero,
                               input logic jump, input logic [31:0] target, input logic trap,
                               input logic [31:0] tvec, input logic rdy, input logic [31:0] epc,
                               input logic eflush, input logic eredir);
    vec_t v;
    v.stall = stall; v.br_en = br_en; v.br_zero = br_zero; v.jump = jump;
    v.target = target; v.trap = trap; v.tvec = tvec; v.rdy = rdy;
    v.epc = epc; v.eflush = eflush; v.eredir = eredir;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic stall, input logic br_en, input logic br_zero, input logic jump,
                       input logic [31:0] target, input logic trap, input logic [31:0] tvec,
                       input logic rdy);
    bus.stall_i = stall; bus.br_en_i = br_en; bus.br_zero_i = br_zero; bus.jump_i = jump;
    bus.target_i = target; bus.trap_i = trap; bus.trap_vec_i = tvec; bus.if_ready_i = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic vld,
                         input logic fl, input logic rd, input logic mis);
    chk({tag, " pc"},       bus.pc_o,       pc);
    chk({tag, " valid"},    {31'd0, bus.pc_valid_o}, {31'd0, vld});
    chk({tag, " flush"},    {31'd0, bus.flush_o},    {31'd0, fl});
    chk({tag, " redirect"}, {31'd0, bus.redirect_o}, {31'd0, rd});
    chk({tag, " misalign"}, {31'd0, bus.misalign_o}, {31'd0, mis});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    //             stall br_en br_z jump target        trap tvec          rdy  exp_pc        fl  rd
    vecs[0]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h300,      1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0); // boot ignores jump
    vecs[1]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 1'b0);
    vecs[2]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h8,        1'b0, 1'b0);
    vecs[3]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, 32'h100,      1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 1'b0); // not taken
    vecs[4]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 32'h100,      1'b0, 32'h0,        1'b1, 32'h10,       1'b0, 1'b0); // br_zero w/o br_en
    vecs[5]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 32'h100,      1'b0, 32'h0,        1'b1, 32'h100,      1'b1, 1'b1); // taken
    vecs[6]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h104,      1'b1, 1'b0);
    vecs[7]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h108,      1'b0, 1'b0); // flush was 2 cycles
    vecs[8]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h10C,      1'b0, 1'b0);
    vecs[9]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h21,       1'b0, 32'h0,        1'b1, 32'h20,       1'b1, 1'b1); // jump, bit0 cleared
    vecs[10] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h20,       1'b1, 1'b0); // fetch not ready
    vecs[11] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h20,       1'b0, 1'b0);
    vecs[12] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h20,       1'b0, 1'b0);
    vecs[13] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h41,       1'b0, 32'h0,        1'b0, 32'h40,       1'b1, 1'b1); // jump over wait
    vecs[14] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h40,       1'b1, 1'b0); // stall holds
    vecs[15] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h44,       1'b0, 1'b0);
    vecs[16] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h200,      1'b1, 32'h80,       1'b1, 32'h80,       1'b1, 1'b1); // trap beats jump
    vecs[17] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h200,      1'b0, 32'h0,        1'b0, 32'h80,       1'b1, 1'b0); // jump in flush ignored
    vecs[18] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h180,      1'b1, 32'h180,      1'b1, 1'b1); // trap in flush reloads
    vecs[19] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 32'h500,      1'b0, 32'h0,        1'b0, 32'h180,      1'b1, 1'b0); // branch in flush ignored
    vecs[20] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h184,      1'b0, 1'b0);
    vecs[21] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFF8, 1'b1, 1'b1); // trap beats stall
    vecs[22] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    vecs[23] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0); // wraps
    vecs[24] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 1'b0);

    rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #2;
    chk_all("boot", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].br_en, vecs[i].br_zero, vecs[i].jump,
            vecs[i].target, vecs[i].trap, vecs[i].tvec, vecs[i].rdy);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].epc, 1'b1, vecs[i].eflush, vecs[i].eredir, 1'b0);
    end

    // Jump to 0x102 from pc 0x4 in S_RUN.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b1);
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    chk_all("mis_a", 32'h4, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    tick();
    chk_all("mis_b", 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    chk_all("mis_a", 32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();
    tick();
    chk_all("mis_b", 32'h104, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    // Trap with a misaligned jump alongside: trap wins, no misalign check.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h102, 1'b1, 32'h40, 1'b1);
    tick();
    chk_all("trap_mis", 32'h40, 1'b1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of the flush window.
    idle();
    rst_n = 1'b0;
    #2;
    chk_all("arst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    chk_all("reboot", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("rerun0", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("rerun1", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
